// File: rtl/comparator_pkg.sv
// Shared verdict encoding and skid-buffer state type for the split magnitude comparator.
package comparator_pkg;

  localparam logic [1:0] CMP_LT  = 2'b10;
  localparam logic [1:0] CMP_GT  = 2'b01;
  localparam logic [1:0] CMP_EQ  = 2'b00;
  localparam logic [1:0] CMP_ILL = 2'b11;

  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b01,
    StTwo   = 2'b10
  } skid_state_e;

  function automatic logic cmp_ge(logic [1:0] cmp);
    return (cmp == CMP_GT) || (cmp == CMP_EQ);
  endfunction

endpackage

// File: rtl/comparator_s2_if.sv
// Token-in / verdict-out handshake bundle for comparator stage 2.
interface comparator_s2_if #(
  parameter int unsigned LSB_W = 7,
  parameter int unsigned TAG_W = 4
);
  logic             valid_i;
  logic             ready_o;
  logic [1:0]       feedback_i;
  logic [LSB_W-1:0] a_lsb_i;
  logic [LSB_W-1:0] b_lsb_i;
  logic [TAG_W-1:0] tag_i;
  logic             valid_o;
  logic             ready_i;
  logic [1:0]       cmp_o;
  logic             a_ge_b_o;
  logic             err_o;
  logic [TAG_W-1:0] tag_o;

  modport master (
    output valid_i, feedback_i, a_lsb_i, b_lsb_i, tag_i, ready_i,
    input  ready_o, valid_o, cmp_o, a_ge_b_o, err_o, tag_o
  );

  modport slave (
    input  valid_i, feedback_i, a_lsb_i, b_lsb_i, tag_i, ready_i,
    output ready_o, valid_o, cmp_o, a_ge_b_o, err_o, tag_o
  );
endinterface

// File: rtl/comparator_lsb.sv
// Combinational verdict: merges the stage-1 MSB verdict with an unsigned LSB compare.
module comparator_lsb
  import comparator_pkg::*;
#(
  parameter int unsigned LSB_W = 7
) (
  input  logic [1:0]       feedback,
  input  logic [LSB_W-1:0] a_lsb,
  input  logic [LSB_W-1:0] b_lsb,
  output logic [1:0]       cmp,
  output logic             a_ge_b,
  output logic             err
);

  always_comb begin
    cmp = CMP_ILL;
    case (feedback)
      CMP_LT: cmp = CMP_LT;
      CMP_GT: cmp = CMP_GT;
      CMP_EQ: begin
        if (a_lsb < b_lsb)      cmp = CMP_LT;
        else if (a_lsb > b_lsb) cmp = CMP_GT;
        else                    cmp = CMP_EQ;
      end
      default: cmp = CMP_ILL;
    endcase
  end

  assign a_ge_b = cmp_ge(cmp);
  assign err    = (feedback == CMP_ILL);

endmodule

// File: rtl/comparator_s2.sv
// Comparator stage 2: verdict logic behind a valid/ready output register.
// Define COMP_S2_SKID_EN for a 2-entry skid buffer with a registered ready_o.
module comparator_s2
  import comparator_pkg::*;
#(
  parameter int unsigned LSB_W = 7,
  parameter int unsigned TAG_W = 4
) (
  input logic            clk_i,
  input logic            rst_i,
  comparator_s2_if.slave bus
);

  localparam int unsigned PayW = TAG_W + 4;

  logic [1:0]      cmp_n;
  logic            a_ge_b_n;
  logic            err_n;
  logic [PayW-1:0] pay_in;
  logic [PayW-1:0] head_q;
  logic            valid_q;
  logic            accept;

  comparator_lsb #(
    .LSB_W(LSB_W)
  ) u_lsb (
    .feedback(bus.feedback_i),
    .a_lsb   (bus.a_lsb_i),
    .b_lsb   (bus.b_lsb_i),
    .cmp     (cmp_n),
    .a_ge_b  (a_ge_b_n),
    .err     (err_n)
  );

  assign pay_in  = {cmp_n, a_ge_b_n, err_n, bus.tag_i};
  assign accept  = bus.valid_i & bus.ready_o;
  assign bus.valid_o = valid_q;
  assign {bus.cmp_o, bus.a_ge_b_o, bus.err_o, bus.tag_o} = head_q;

`ifdef COMP_S2_SKID_EN
  skid_state_e     state_q;
  logic            ready_q;
  logic [PayW-1:0] skid_q;

  assign bus.ready_o = ready_q;

  // head_q is always the oldest token; skid_q only holds the one caught during a stall.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StEmpty;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      case (state_q)
        StEmpty: begin
          if (accept) begin
            head_q  <= pay_in;
            valid_q <= 1'b1;
            state_q <= StOne;
          end
        end
        StOne: begin
          if (accept && !bus.ready_i) begin
            skid_q  <= pay_in;
            state_q <= StTwo;
            ready_q <= 1'b0;
          end else if (accept) begin
            head_q <= pay_in;
          end else if (bus.ready_i) begin
            valid_q <= 1'b0;
            state_q <= StEmpty;
          end
        end
        StTwo: begin
          if (bus.ready_i) begin
            head_q  <= skid_q;
            state_q <= StOne;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= StEmpty;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end
`else
  assign bus.ready_o = ~valid_q | bus.ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      head_q  <= '0;
    end else if (accept) begin
      head_q  <= pay_in;
      valid_q <= 1'b1;
    end else if (bus.ready_i) begin
      valid_q <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_comparator_s2.sv
// Self-checking bench for comparator_s2: directed cases plus a randomized scoreboard
// against a 16-bit reference compare.
module tb_comparator_s2;

  localparam int unsigned LSB_W = 7;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned NTok  = 10000;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  comparator_s2_if #(.LSB_W(LSB_W), .TAG_W(TAG_W)) bus ();

  comparator_s2 #(.LSB_W(LSB_W), .TAG_W(TAG_W)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit v, input logic [1:0] fb, input logic [6:0] a,
                       input logic [6:0] b, input logic [3:0] t);
    bus.valid_i    = v;
    bus.feedback_i = fb;
    bus.a_lsb_i    = a;
    bus.b_lsb_i    = b;
    bus.tag_i      = t;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_valid"}, 32'(bus.valid_o), 32'd0);
    check({tag, "_cmp"}, 32'(bus.cmp_o), 32'd0);
    check({tag, "_ge"}, 32'(bus.a_ge_b_o), 32'd0);
    check({tag, "_err"}, 32'(bus.err_o), 32'd0);
    check({tag, "_tag"}, 32'(bus.tag_o), 32'd0);
    check({tag, "_ready"}, 32'(bus.ready_o), 32'd1);
  endtask

  // Stage-1 stand-in: verdict on the 9 MSBs only.
  function automatic logic [1:0] msb_verdict(input int unsigned am, input int unsigned bm,
                                             input bit ill);
    if (ill) return 2'b11;
    if (am < bm) return 2'b10;
    if (am > bm) return 2'b01;
    return 2'b00;
  endfunction

  // Expected {cmp, a_ge_b, err, tag} from the full 16-bit operands.
  function automatic logic [7:0] ref_tok(input int unsigned a16, input int unsigned b16,
                                         input bit ill, input logic [3:0] t);
    logic [1:0] c;
    if (ill)            c = 2'b11;
    else if (a16 < b16) c = 2'b10;
    else if (a16 > b16) c = 2'b01;
    else                c = 2'b00;
    return {c, (!ill && a16 >= b16), ill, t};
  endfunction

  function automatic logic [7:0] out_tok();
    return {bus.cmp_o, bus.a_ge_b_o, bus.err_o, bus.tag_o};
  endfunction

  logic [1:0] eq_exp [3];
  logic [6:0] eq_a   [3];
  logic [6:0] eq_b   [3];
  logic [7:0] sb     [$];

  initial begin
    rst         = 1'b1;
    bus.ready_i = 1'b1;
    drive(1'b0, 2'b00, 7'h00, 7'h00, 4'h0);
    step();
    step();
    check_reset("reset");
    rst = 1'b0;

    // Stage-1 says A<B: LSBs ignored.
    drive(1'b1, 2'b10, 7'h7f, 7'h00, 4'h1);
    step();
    check("lt_valid", 32'(bus.valid_o), 32'd1);
    check("lt_cmp", 32'(bus.cmp_o), 32'h2);
    check("lt_ge", 32'(bus.a_ge_b_o), 32'd0);
    check("lt_tag", 32'(bus.tag_o), 32'h1);
    bus.valid_i = 1'b0;
    step();
    check("lt_onecycle", 32'(bus.valid_o), 32'd0);

    // Back-to-back LSB resolution.
    eq_a = '{7'h12, 7'h12, 7'h13};
    eq_b = '{7'h12, 7'h13, 7'h12};
    eq_exp = '{2'b00, 2'b10, 2'b01};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b00, eq_a[i], eq_b[i], 4'(i + 2));
      step();
      check("b2b_valid", 32'(bus.valid_o), 32'd1);
      check("b2b_cmp", 32'(bus.cmp_o), 32'(eq_exp[i]));
      check("b2b_tag", 32'(bus.tag_o), 32'(i + 2));
    end
    bus.valid_i = 1'b0;
    step();

    // Stall with downstream not ready.
    bus.ready_i = 1'b0;
    drive(1'b1, 2'b00, 7'h01, 7'h02, 4'h5);
    step();
    drive(1'b1, 2'b01, 7'h00, 7'h00, 4'h6);
    for (int i = 0; i < 5; i++) begin
      #1;
`ifdef COMP_S2_SKID_EN
      check("stall_ready", 32'(bus.ready_o), (i == 0) ? 32'd1 : 32'd0);
`else
      check("stall_ready", 32'(bus.ready_o), 32'd0);
`endif
      check("stall_valid", 32'(bus.valid_o), 32'd1);
      check("stall_tag", 32'(bus.tag_o), 32'h5);
      check("stall_cmp", 32'(bus.cmp_o), 32'h2);
      step();
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    #1;
    check("drain_first", 32'(out_tok()), 32'({2'b10, 1'b0, 1'b0, 4'h5}));
    step();
`ifdef COMP_S2_SKID_EN
    check("drain_second_valid", 32'(bus.valid_o), 32'd1);
    check("drain_second", 32'(out_tok()), 32'({2'b01, 1'b1, 1'b0, 4'h6}));
    step();
`endif
    check("drain_empty", 32'(bus.valid_o), 32'd0);

    // Illegal stage-1 verdict.
    drive(1'b1, 2'b11, 7'h05, 7'h01, 4'h9);
    step();
    check("ill_cmp", 32'(bus.cmp_o), 32'h3);
    check("ill_err", 32'(bus.err_o), 32'd1);
    check("ill_ge", 32'(bus.a_ge_b_o), 32'd0);
    bus.valid_i = 1'b0;
    step();

    // Reset while a token is held and another is offered.
    bus.ready_i = 1'b0;
    drive(1'b1, 2'b01, 7'h00, 7'h00, 4'ha);
    step();
    check("rst_pre_valid", 32'(bus.valid_o), 32'd1);
    rst = 1'b1;
    drive(1'b1, 2'b10, 7'h00, 7'h00, 4'hb);
    step();
    check_reset("midrst");
    rst = 1'b0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    step();
    check("post_rst_a", 32'(bus.valid_o), 32'd0);
    step();
    check("post_rst_b", 32'(bus.valid_o), 32'd0);

    // Randomized scoreboard run.
    begin
      int unsigned sent = 0;
      int unsigned drained = 0;
      int unsigned cyc = 0;
      int unsigned am, bm, al, bl;
      bit ill;
      logic [3:0] t;
      logic [7:0] exp_tok;
      while (drained < NTok && cyc < 80000) begin
        am  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 2) : $urandom_range(0, 511);
        bm  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 2) : $urandom_range(0, 511);
        al  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 127);
        bl  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 127);
        ill = ($urandom_range(0, 15) == 0);
        t   = 4'($urandom);
        drive((sent < NTok) && ($urandom_range(0, 3) != 0), msb_verdict(am, bm, ill),
              7'(al), 7'(bl), t);
        bus.ready_i = ($urandom_range(0, 3) != 0);
        #1;
        if (bus.valid_o && bus.ready_i) begin
          if (sb.size() == 0) begin
            check("rnd_spurious", 32'(out_tok()), 32'hffff_ffff);
          end else begin
            exp_tok = sb.pop_front();
            check("rnd_tok", 32'(out_tok()), 32'(exp_tok));
          end
          drained++;
        end
        if (bus.valid_i && bus.ready_o) begin
          sb.push_back(ref_tok((am << 7) | al, (bm << 7) | bl, ill, t));
          sent++;
        end
        step();
        cyc++;
      end
      check("rnd_drained", drained, NTok);
      check("rnd_sb_empty", 32'(sb.size()), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
